// File: rtl/dog_motion_sched_if.sv
// Command handshake between the display controller and the dog motion scheduler.
// The master requests an action and the scheduler signals when its pending slot can take it.
interface dog_motion_sched_if;
    logic       cmd_valid;
    logic [2:0] cmd_action;
    logic       cmd_ready;

    modport master (output cmd_valid, output cmd_action, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_action, output cmd_ready);
endinterface

// File: rtl/dog_motion_sched.sv
// Frame-rate dog sprite scheduler: autonomous sit/walk patrol plus commanded walks and jumps.
// Define DOG_WRAP_EN to make walks wrap around the screen edges instead of bouncing into SIT.
module dog_motion_sched #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 576,
    parameter int Y_GROUND = 400,
    parameter int JUMP_H   = 64,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 4,
    parameter int DWELL    = 60,
    parameter int ANIM_DIV = 8
) (
    input  logic                     pixel_clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     frame_tick,
    dog_motion_sched_if.slave        cmd,
    output logic [2:0]               ActionSel,
    output logic [9:0]               DogPos_x,
    output logic [8:0]               DogPos_y,
    output logic [1:0]               anim_frame,
    output logic                     busy
);

    typedef enum logic [2:0] {
        SIT       = 3'd0,
        WALK_R    = 3'd1,
        WALK_L    = 3'd2,
        JUMP_UP   = 3'd3,
        JUMP_DOWN = 3'd4
    } state_e;

    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int DIV_W = $clog2(ANIM_DIV + 1);

    localparam logic [10:0]      X_MIN_W    = 11'(X_MIN);
    localparam logic [10:0]      X_MAX_W    = 11'(X_MAX);
    localparam logic [10:0]      STEP_X_W   = 11'(STEP_X);
    localparam logic [9:0]       Y_GND_W    = 10'(Y_GROUND);
    localparam logic [9:0]       Y_APEX_W   = 10'(Y_GROUND - JUMP_H);
    localparam logic [9:0]       STEP_Y_W   = 10'(STEP_Y);
    localparam logic [9:0]       X_MIN_P    = 10'(X_MIN);
    localparam logic [9:0]       X_MAX_P    = 10'(X_MAX);
    localparam logic [8:0]       Y_GND_P    = 9'(Y_GROUND);
    localparam logic [8:0]       Y_APEX_P   = 9'(Y_GROUND - JUMP_H);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ANIM_DIV - 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [9:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             next_right_q, next_right_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_act_q, pend_act_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       anim_q, anim_d;
    logic             busy_q, busy_d;

    logic        jumping;
    logic        ready;
    logic        anim_step;
    logic [10:0] x_inc, x_dec;
    logic [9:0]  y_up, y_dn;

    assign jumping        = (state_q == JUMP_UP) || (state_q == JUMP_DOWN);
    assign ready          = ~pend_valid_q & ~jumping;
    assign cmd.cmd_ready  = ready;

    assign x_inc = {1'b0, x_q} + STEP_X_W;
    assign x_dec = {1'b0, x_q} - STEP_X_W;
    assign y_up  = {1'b0, y_q} - STEP_Y_W;
    assign y_dn  = {1'b0, y_q} + STEP_Y_W;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d      = state_q;
        ret_d        = ret_q;
        x_d          = x_q;
        y_d          = y_q;
        dwell_d      = dwell_q;
        next_right_d = next_right_q;
        pend_valid_d = pend_valid_q;
        pend_act_d   = pend_act_q;
        div_d        = div_q;
        anim_d       = anim_q;
        anim_step    = 1'b0;

        // Codes outside 1..3 complete the handshake but never occupy the slot.
        if (cmd.cmd_valid && ready && (cmd.cmd_action inside {3'd1, 3'd2, 3'd3})) begin
            pend_valid_d = 1'b1;
            pend_act_d   = cmd.cmd_action[1:0];
        end

        if (run && frame_tick) begin
            if (pend_valid_q && !jumping) begin
                pend_valid_d = 1'b0;
                dwell_d      = '0;
                case (pend_act_q)
                    2'd1:    state_d = WALK_R;
                    2'd2:    state_d = WALK_L;
                    default: begin
                        ret_d   = state_q;
                        state_d = JUMP_UP;
                    end
                endcase
            end else begin
                case (state_q)
                    SIT: begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = next_right_q ? WALK_R : WALK_L;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                    WALK_R: begin
                        anim_step = 1'b1;
`ifdef DOG_WRAP_EN
                        x_d = (x_inc > X_MAX_W) ? X_MIN_P : x_inc[9:0];
`else
                        if (x_inc >= X_MAX_W) begin
                            x_d          = X_MAX_P;
                            state_d      = SIT;
                            next_right_d = 1'b0;
                            dwell_d      = '0;
                        end else begin
                            x_d = x_inc[9:0];
                        end
`endif
                    end
                    WALK_L: begin
                        anim_step = 1'b1;
`ifdef DOG_WRAP_EN
                        x_d = ({1'b0, x_q} < X_MIN_W + STEP_X_W) ? X_MAX_P : x_dec[9:0];
`else
                        if ({1'b0, x_q} <= X_MIN_W + STEP_X_W) begin
                            x_d          = X_MIN_P;
                            state_d      = SIT;
                            next_right_d = 1'b1;
                            dwell_d      = '0;
                        end else begin
                            x_d = x_dec[9:0];
                        end
`endif
                    end
                    JUMP_UP: begin
                        if (y_up <= Y_APEX_W) begin
                            y_d     = Y_APEX_P;
                            state_d = JUMP_DOWN;
                        end else begin
                            y_d = y_up[8:0];
                        end
                    end
                    JUMP_DOWN: begin
                        if (y_dn >= Y_GND_W) begin
                            y_d     = Y_GND_P;
                            state_d = ret_q;
                            dwell_d = '0;
                        end else begin
                            y_d = y_dn[8:0];
                        end
                    end
                    default: state_d = SIT;
                endcase
            end
        end

        if (anim_step) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                anim_d = anim_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        // Any change of state, or any non-walk state, restarts the walk animation.
        if ((state_d != state_q) || !((state_d == WALK_R) || (state_d == WALK_L))) begin
            div_d  = '0;
            anim_d = '0;
        end

        busy_d = (state_d == JUMP_UP) || (state_d == JUMP_DOWN);
    end

    // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SIT;
            ret_q        <= SIT;
            x_q          <= X_MIN_P;
            y_q          <= Y_GND_P;
            dwell_q      <= '0;
            next_right_q <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_act_q   <= 2'd0;
            div_q        <= '0;
            anim_q       <= 2'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dwell_q      <= dwell_d;
            next_right_q <= next_right_d;
            pend_valid_q <= pend_valid_d;
            pend_act_q   <= pend_act_d;
            div_q        <= div_d;
            anim_q       <= anim_d;
            busy_q       <= busy_d;
        end
    end

    assign ActionSel  = state_q;
    assign DogPos_x   = x_q;
    assign DogPos_y   = y_q;
    assign anim_frame = anim_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dog_motion_sched.sv
// Directed bench for dog_motion_sched: patrol timing, jump, run freeze, command handshake, edges.
// Expected values are hand-derived; the edge section follows DOG_WRAP_EN like the design.
module tb_dog_motion_sched;

    logic       pixel_clk;
    logic       reset;
    logic       run;
    logic       frame_tick;
    logic [2:0] ActionSel;
    logic [9:0] DogPos_x;
    logic [8:0] DogPos_y;
    logic [1:0] anim_frame;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt;

    dog_motion_sched_if cmd_if ();

    dog_motion_sched dut (
        .pixel_clk  (pixel_clk),
        .reset      (reset),
        .run        (run),
        .frame_tick (frame_tick),
        .cmd        (cmd_if),
        .ActionSel  (ActionSel),
        .DogPos_x   (DogPos_x),
        .DogPos_y   (DogPos_y),
        .anim_frame (anim_frame),
        .busy       (busy)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame: tick cycle then an idle cycle; returns #1 after a rising edge.
    task automatic tick();
        frame_tick = 1'b1;
        @(posedge pixel_clk); #1;
        frame_tick = 1'b0;
        @(posedge pixel_clk); #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [2:0] act);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_action = act;
        @(posedge pixel_clk); #1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_action = 3'd0;
    endtask

    initial begin
        reset             = 1'b0;
        run               = 1'b0;
        frame_tick        = 1'b0;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_action = 3'd0;
        repeat (10) @(posedge pixel_clk);
        #1 reset = 1'b1;
        @(posedge pixel_clk); #1;

        check("rst_action", ActionSel, 0);
        check("rst_x", DogPos_x, 0);
        check("rst_y", DogPos_y, 400);
        check("rst_anim", anim_frame, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_if.cmd_ready, 1);

        // Patrol: 59 ticks still sitting, 60th enters WALK_R without moving.
        run = 1'b1;
        ticks(59);
        check("sit59_action", ActionSel, 0);
        check("sit59_x", DogPos_x, 0);
        tick();
        check("sit60_action", ActionSel, 1);
        check("sit60_x", DogPos_x, 0);
        check("sit60_y", DogPos_y, 400);

        ticks(7);
        check("walk7_anim", anim_frame, 0);
        tick();
        check("walk8_x", DogPos_x, 16);
        check("walk8_anim", anim_frame, 1);
        ticks(42);
        check("walk50_x", DogPos_x, 100);
        check("walk50_anim", anim_frame, 2);

        // Jump from WALK_R at x=100.
        check("pre_jump_ready", cmd_if.cmd_ready, 1);
        send_cmd(3'd3);
        check("jump_pending_ready", cmd_if.cmd_ready, 0);
        check("jump_pending_action", ActionSel, 1);
        tick();
        busy_cnt = busy ? 1 : 0;
        check("jump_enter_action", ActionSel, 3);
        check("jump_enter_y", DogPos_y, 400);
        check("jump_enter_anim", anim_frame, 0);
        check("jump_ready", cmd_if.cmd_ready, 0);
        tick();
        if (busy) busy_cnt++;
        check("jump_up1_y", DogPos_y, 396);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("apex_y", DogPos_y, 336);
        check("apex_action", ActionSel, 4);
        check("apex_x", DogPos_x, 100);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("land_y", DogPos_y, 400);
        check("land_action", ActionSel, 1);
        check("land_x", DogPos_x, 100);
        check("land_ready", cmd_if.cmd_ready, 1);
        check("busy_ticks", busy_cnt, 32);

        // Freeze mid-walk; commands still land in the slot.
        ticks(9);
        check("walk9_x", DogPos_x, 118);
        check("walk9_anim", anim_frame, 1);
        run = 1'b0;
        ticks(50);
        check("frozen_x", DogPos_x, 118);
        check("frozen_action", ActionSel, 1);
        check("frozen_anim", anim_frame, 1);
        check("frozen_ready", cmd_if.cmd_ready, 1);
        send_cmd(3'd2);
        check("frozen_accept_ready", cmd_if.cmd_ready, 0);
        tick();
        check("frozen_cmd_action", ActionSel, 1);
        run = 1'b1;
        tick();
        check("resume_action", ActionSel, 2);
        check("resume_x", DogPos_x, 118);
        check("resume_anim", anim_frame, 0);
        check("resume_ready", cmd_if.cmd_ready, 1);

        // Invalid code held: always accepted, never stored.
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_action = 3'd6;
        for (int i = 0; i < 4; i++) begin
            @(posedge pixel_clk); #1;
            check("bad_code_ready", cmd_if.cmd_ready, 1);
        end
        tick();
        check("bad_code_action", ActionSel, 2);
        check("bad_code_x", DogPos_x, 116);
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_action = 3'd0;

        // Command accepted on a tick cycle is applied on the following tick.
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_action = 3'd1;
        frame_tick        = 1'b1;
        @(posedge pixel_clk); #1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_action = 3'd0;
        frame_tick        = 1'b0;
        @(posedge pixel_clk); #1;
        check("same_tick_action", ActionSel, 2);
        check("same_tick_x", DogPos_x, 114);
        check("same_tick_ready", cmd_if.cmd_ready, 0);
        tick();
        check("next_tick_action", ActionSel, 1);
        check("next_tick_x", DogPos_x, 114);

        // Walk left towards the left edge.
        send_cmd(3'd2);
        tick();
        check("walkl_action", ActionSel, 2);
        for (int i = 1; i <= 56; i++) begin
            tick();
            check("walkl_x", DogPos_x, 114 - 2 * i);
        end
        check("walkl56_action", ActionSel, 2);
        tick();
        check("left_edge_x", DogPos_x, 0);
`ifdef DOG_WRAP_EN
        check("left_edge_action", ActionSel, 2);
        tick();
        check("wrap_left_x", DogPos_x, 576);
        check("wrap_left_action", ActionSel, 2);
        tick();
        check("wrap_left2_x", DogPos_x, 574);
        send_cmd(3'd1);
        tick();
        check("wrap_r_enter_action", ActionSel, 1);
        check("wrap_r_enter_x", DogPos_x, 574);
        tick();
        check("wrap_r_576_x", DogPos_x, 576);
        check("wrap_r_576_action", ActionSel, 1);
        tick();
        check("wrap_r_0_x", DogPos_x, 0);
        check("wrap_r_0_action", ActionSel, 1);
`else
        check("left_edge_action", ActionSel, 0);
        ticks(59);
        check("sit_l59_action", ActionSel, 0);
        tick();
        check("sit_l60_action", ActionSel, 1);
        check("sit_l60_x", DogPos_x, 0);
        ticks(287);
        check("walk_r287_x", DogPos_x, 574);
        check("walk_r287_action", ActionSel, 1);
        tick();
        check("right_edge_x", DogPos_x, 576);
        check("right_edge_action", ActionSel, 0);
        ticks(60);
        check("sit_r60_action", ActionSel, 2);
        check("sit_r60_x", DogPos_x, 576);
        tick();
        check("walkl1_x", DogPos_x, 574);
`endif

        // Asynchronous reset mid-walk with a command pending.
        send_cmd(3'd1);
        check("pre_rst_ready", cmd_if.cmd_ready, 0);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_action", ActionSel, 0);
        check("mid_rst_x", DogPos_x, 0);
        check("mid_rst_y", DogPos_y, 400);
        check("mid_rst_anim", anim_frame, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_if.cmd_ready, 1);
        @(posedge pixel_clk); #1;
        reset = 1'b1;
        tick();
        check("post_rst_action", ActionSel, 0);
        check("post_rst_x", DogPos_x, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
